// File: rtl/pc_update_unit_pkg.sv
// Shared types and constants for the PC update unit: FSM states, branch
// encodings, exception cause codes and vector addresses.
package pc_update_unit_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_EXC_SAVE   = 2'd1,
        ST_EXC_VECTOR = 2'd2
    } state_t;

    localparam logic [1:0] BR_BEQ  = 2'd0;
    localparam logic [1:0] BR_BNE  = 2'd1;
    localparam logic [1:0] BR_BLEZ = 2'd2;
    localparam logic [1:0] BR_BGT  = 2'd3;

    localparam logic [1:0] CAUSE_OPCODE = 2'd0;
    localparam logic [1:0] CAUSE_OVF    = 2'd1;
    localparam logic [1:0] CAUSE_DIV0   = 2'd2;
    localparam logic [1:0] CAUSE_ALIGN  = 2'd3;

    localparam logic [31:0] EXC_VEC_OPCODE = 32'h0000_0100;
    localparam logic [31:0] EXC_VEC_OVF    = 32'h0000_0104;
    localparam logic [31:0] EXC_VEC_DIV0   = 32'h0000_0108;
    localparam logic [31:0] EXC_VEC_ALIGN  = 32'h0000_010C;
    localparam logic [31:0] RESET_PC       = 32'h0000_0000;

    // Control never legitimately raises the alignment cause; fold it to invalid opcode.
    function automatic logic [1:0] normalizeCause(input logic [1:0] code);
        return (code == CAUSE_ALIGN) ? CAUSE_OPCODE : code;
    endfunction

    function automatic logic [31:0] excVector(input logic [1:0] cause);
        logic [31:0] vec;
        case (cause)
            CAUSE_OPCODE: vec = EXC_VEC_OPCODE;
            CAUSE_OVF:    vec = EXC_VEC_OVF;
            CAUSE_DIV0:   vec = EXC_VEC_DIV0;
            default:      vec = EXC_VEC_ALIGN;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/pc_update_unit_branch_cond_eval.sv
// Combinational branch condition evaluator: decides whether a conditional
// PC load is taken from the branch type and the ALU compare flags.
module branch_cond_eval
    import pc_update_unit_pkg::*;
(
    input  logic [1:0] i_branchType,
    input  logic       i_aluZero,
    input  logic       i_aluNeg,
    output logic       o_takeBranch
);

    always_comb begin
        o_takeBranch = 1'b0;
        case (i_branchType)
            BR_BEQ:  o_takeBranch = i_aluZero;
            BR_BNE:  o_takeBranch = ~i_aluZero;
            BR_BLEZ: o_takeBranch = i_aluZero | i_aluNeg;
            BR_BGT:  o_takeBranch = ~i_aluZero & ~i_aluNeg;
            default: o_takeBranch = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_update_unit.sv
// PC register with branch-conditional loads and a two-cycle exception
// sequence (save EPC, then vector). Define PC_ALIGN_CHECK_EN to trap misaligned loads.
module pc_update_unit
    import pc_update_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic [1:0]  branch_type,
    input  logic        alu_zero,
    input  logic        alu_neg,
    input  logic        exc_req,
    input  logic [1:0]  exc_code,
    output logic [31:0] pc_out,
    output logic [31:0] epc_out,
    output logic [1:0]  cause_out,
    output logic        busy
);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic [1:0]  r_cause;
    logic        r_busy;

    logic w_takeBranch;
    logic w_loadReq;
    logic w_alignFault;

    branch_cond_eval u_branchCond (
        .i_branchType (branch_type),
        .i_aluZero    (alu_zero),
        .i_aluNeg     (alu_neg),
        .o_takeBranch (w_takeBranch)
    );

    assign w_loadReq = pc_write | (pc_write_cond & w_takeBranch);

`ifdef PC_ALIGN_CHECK_EN
    assign w_alignFault = w_loadReq & (next_pc[1:0] != 2'b00);
`else
    assign w_alignFault = 1'b0;
`endif

    // Loads and exception requests are only honoured in RUN; while busy they are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_epc   <= 32'h0000_0000;
            r_cause <= CAUSE_OPCODE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (exc_req) begin
                        r_cause <= normalizeCause(exc_code);
                        r_state <= ST_EXC_SAVE;
                        r_busy  <= 1'b1;
                    end else if (w_alignFault) begin
                        r_cause <= CAUSE_ALIGN;
                        r_state <= ST_EXC_SAVE;
                        r_busy  <= 1'b1;
                    end else if (w_loadReq) begin
                        r_pc <= next_pc;
                    end
                end
                ST_EXC_SAVE: begin
                    r_epc   <= r_pc - 32'd4;
                    r_state <= ST_EXC_VECTOR;
                end
                ST_EXC_VECTOR: begin
                    r_pc    <= excVector(r_cause);
                    r_state <= ST_RUN;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out    = r_pc;
    assign epc_out   = r_epc;
    assign cause_out = r_cause;
    assign busy      = r_busy;

endmodule

// File: tb/tb_pc_update_unit.sv
// Testbench for pc_update_unit: directed vector table, alignment sequence,
// then randomized traffic against a cycle-level reference model.
module tb_pc_update_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] next_pc;
    logic        pc_write;
    logic        pc_write_cond;
    logic [1:0]  branch_type;
    logic        alu_zero;
    logic        alu_neg;
    logic        exc_req;
    logic [1:0]  exc_code;
    logic [31:0] pc_out;
    logic [31:0] epc_out;
    logic [1:0]  cause_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] mPc;
    logic [31:0] mEpc;
    logic [1:0]  mCause;
    int          mPending;

    typedef struct {
        logic        rst;
        logic        pw;
        logic        pwc;
        logic [1:0]  bt;
        logic        z;
        logic        n;
        logic        exc;
        logic [1:0]  code;
        logic [31:0] np;
        logic [31:0] ePc;
        logic [31:0] eEpc;
        logic [1:0]  eCause;
        logic        eBusy;
    } vec_t;

    vec_t vecs[22];

    pc_update_unit dut (
        .clk           (clk),
        .reset         (reset),
        .next_pc       (next_pc),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_type   (branch_type),
        .alu_zero      (alu_zero),
        .alu_neg       (alu_neg),
        .exc_req       (exc_req),
        .exc_code      (exc_code),
        .pc_out        (pc_out),
        .epc_out       (epc_out),
        .cause_out     (cause_out),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input vec_t v);
        reset         = v.rst;
        pc_write      = v.pw;
        pc_write_cond = v.pwc;
        branch_type   = v.bt;
        alu_zero      = v.z;
        alu_neg       = v.n;
        exc_req       = v.exc;
        exc_code      = v.code;
        next_pc       = v.np;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Reference model: an exception is a countdown of two cycles after the request.
    task automatic modelStep();
        bit take;
        bit load;
        if (reset) begin
            mPc = 0; mEpc = 0; mCause = 0; mPending = 0;
        end else if (mPending == 2) begin
            mEpc = mPc - 32'd4;
            mPending = 1;
        end else if (mPending == 1) begin
            mPc = 32'h100 + 32'd4 * 32'(mCause);
            mPending = 0;
        end else begin
            case (branch_type)
                2'd0:    take = alu_zero;
                2'd1:    take = !alu_zero;
                2'd2:    take = alu_zero || alu_neg;
                default: take = !alu_zero && !alu_neg;
            endcase
            load = pc_write || (pc_write_cond && take);
            if (exc_req) begin
                mCause = (exc_code == 2'd3) ? 2'd0 : exc_code;
                mPending = 2;
            end else if (load) begin
`ifdef PC_ALIGN_CHECK_EN
                if (next_pc[1:0] != 2'b00) begin
                    mCause = 2'd3;
                    mPending = 2;
                end else begin
                    mPc = next_pc;
                end
`else
                mPc = next_pc;
`endif
            end
        end
    endtask

    task automatic stepCycle();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".pc"}, pc_out, mPc);
        checkOutput({tag, ".epc"}, epc_out, mEpc);
        checkOutput({tag, ".cause"}, 32'(cause_out), 32'(mCause));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(mPending != 0));
    endtask

    initial begin
        vec_t idle;
        idle = '{0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd0, 0};
        applyStimulus(idle);
        @(negedge clk);

        //            rst pw pwc bt    z  n  exc code  next_pc       pc            epc           cause busy
        vecs[0]  = '{1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2'd0, 0};
        vecs[1]  = '{0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_0004, 32'h0000_0004, 32'h0000_0000, 2'd0, 0};
        vecs[2]  = '{0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_0098, 32'h0000_0004, 32'h0000_0000, 2'd0, 0};
        vecs[3]  = '{0, 0, 1, 2'd1, 1, 0, 0, 2'd0, 32'h0000_0040, 32'h0000_0004, 32'h0000_0000, 2'd0, 0};
        vecs[4]  = '{0, 0, 1, 2'd1, 0, 0, 0, 2'd0, 32'h0000_0040, 32'h0000_0040, 32'h0000_0000, 2'd0, 0};
        vecs[5]  = '{0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_0020, 32'h0000_0020, 32'h0000_0000, 2'd0, 0};
        vecs[6]  = '{0, 1, 0, 2'd0, 0, 0, 1, 2'd1, 32'h0000_0080, 32'h0000_0020, 32'h0000_0000, 2'd1, 1};
        vecs[7]  = '{0, 1, 0, 2'd0, 0, 0, 1, 2'd2, 32'h0000_0090, 32'h0000_0020, 32'h0000_001C, 2'd1, 1};
        vecs[8]  = '{0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_0000, 32'h0000_0104, 32'h0000_001C, 2'd1, 0};
        vecs[9]  = '{0, 0, 1, 2'd2, 0, 1, 0, 2'd0, 32'h0000_0200, 32'h0000_0200, 32'h0000_001C, 2'd1, 0};
        vecs[10] = '{0, 0, 1, 2'd3, 0, 1, 0, 2'd0, 32'h0000_0300, 32'h0000_0200, 32'h0000_001C, 2'd1, 0};
        vecs[11] = '{0, 0, 1, 2'd0, 1, 0, 0, 2'd0, 32'h0000_0010, 32'h0000_0010, 32'h0000_001C, 2'd1, 0};
        vecs[12] = '{0, 0, 1, 2'd3, 0, 0, 0, 2'd0, 32'h0000_0014, 32'h0000_0014, 32'h0000_001C, 2'd1, 0};
        vecs[13] = '{0, 0, 1, 2'd2, 0, 0, 0, 2'd0, 32'h0000_0018, 32'h0000_0014, 32'h0000_001C, 2'd1, 0};
        vecs[14] = '{0, 0, 1, 2'd0, 0, 0, 0, 2'd0, 32'h0000_001C, 32'h0000_0014, 32'h0000_001C, 2'd1, 0};
        vecs[15] = '{1, 1, 0, 2'd0, 0, 0, 1, 2'd1, 32'h0000_0050, 32'h0000_0000, 32'h0000_0000, 2'd0, 0};
        vecs[16] = '{0, 0, 0, 2'd0, 0, 0, 1, 2'd3, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2'd0, 1};
        vecs[17] = '{0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFC, 2'd0, 1};
        vecs[18] = '{0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_0000, 32'h0000_0100, 32'hFFFF_FFFC, 2'd0, 0};
        vecs[19] = '{0, 0, 0, 2'd0, 0, 0, 1, 2'd2, 32'h0000_0000, 32'h0000_0100, 32'hFFFF_FFFC, 2'd2, 1};
        vecs[20] = '{1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2'd0, 0};
        vecs[21] = '{0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2'd0, 0};

        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i]);
            stepCycle();
            checkOutput($sformatf("vec%0d.pc", i), pc_out, vecs[i].ePc);
            checkOutput($sformatf("vec%0d.epc", i), epc_out, vecs[i].eEpc);
            checkOutput($sformatf("vec%0d.cause", i), 32'(cause_out), 32'(vecs[i].eCause));
            checkOutput($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].eBusy));
        end

        // Misaligned load from PC 0x8: trapped with the check enabled, loaded as-is otherwise.
        applyStimulus('{0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_0008, 0, 0, 2'd0, 0});
        stepCycle();
        checkOutput("align.setup.pc", pc_out, 32'h0000_0008);
        applyStimulus('{0, 1, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0000_0042, 0, 0, 2'd0, 0});
        stepCycle();
        applyStimulus(idle);
`ifdef PC_ALIGN_CHECK_EN
        checkOutput("align.busy1", 32'(busy), 32'd1);
        checkOutput("align.pcHeld", pc_out, 32'h0000_0008);
        stepCycle();
        checkOutput("align.epc", epc_out, 32'h0000_0004);
        stepCycle();
        checkOutput("align.vector", pc_out, 32'h0000_010C);
        checkOutput("align.cause", 32'(cause_out), 32'd3);
        checkOutput("align.busyDone", 32'(busy), 32'd0);
`else
        checkOutput("align.pcLoaded", pc_out, 32'h0000_0042);
        checkOutput("align.busy", 32'(busy), 32'd0);
        stepCycle();
        checkOutput("align.cause", 32'(cause_out), 32'd0);
`endif

        // Randomized traffic against the reference model, starting from a clean reset.
        applyStimulus('{1, 0, 0, 2'd0, 0, 0, 0, 2'd0, 32'h0, 0, 0, 2'd0, 0});
        stepCycle();
        checkModel("rnd.reset");
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 59) == 0);
            pc_write      = ($urandom_range(0, 3) == 0);
            pc_write_cond = ($urandom_range(0, 2) == 0);
            branch_type   = 2'($urandom_range(0, 3));
            alu_zero      = 1'($urandom_range(0, 1));
            alu_neg       = 1'($urandom_range(0, 1));
            exc_req       = ($urandom_range(0, 9) == 0);
            exc_code      = 2'($urandom_range(0, 3));
            next_pc       = $urandom;
            if ($urandom_range(0, 3) != 0) next_pc[1:0] = 2'b00;
            stepCycle();
            checkModel($sformatf("rnd%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
